// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file.
// Contents:
//   RF_WIDTH, RF_DEPTH : default data width and register count
//   rf_aw()            : address width for a given register count
//   rf_addr_t/rf_data_t: address/data types at the default sizes
//   REG_ZERO           : index of the hardwired-zero register
package rf_pkg;

    localparam int unsigned RF_WIDTH = 32;
    localparam int unsigned RF_DEPTH = 32;

    function automatic int unsigned rf_aw(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned RF_AW = rf_aw(RF_DEPTH);

    typedef logic [RF_AW-1:0]    rf_addr_t;
    typedef logic [RF_WIDTH-1:0] rf_data_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard.
// A register is marked busy at issue (set) and released by the long-latency
// writeback (clear). When both hit the same register in one cycle the set
// wins, because the new issue supersedes the load that is completing.
// Register 0 never becomes busy.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   set_en/set_addr : mark a register busy
//   clr_en/clr_addr : clear a register's busy bit
//   busy_vec   : registered busy state, bit 0 always 0
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = RF_DEPTH,
    localparam int unsigned AW = rf_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [DEPTH-1:0] busy_vec
);

    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = '0;
        for (int unsigned r = 1; r < DEPTH; r++) begin
            busy_d[r] = (set_en && (set_addr == AW'(r)))
                      | (busy_vec[r] & ~(clr_en && (clr_addr == AW'(r))));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_d;
        end
    end

endmodule

// File: rtl/rf_multiport_sb.sv
// Register file with NUM_RD asynchronous read ports, two write ports and a
// per-register busy scoreboard.
//   W0 : ALU writeback, data only.
//   W1 : memory writeback, has priority over W0 and clears the busy bit.
// Register 0 reads as zero, ignores writes and is never busy.
// Optional macro RF_BYPASS_EN: read ports forward same-cycle write data
// (W1 over W0 over stored) and same-cycle busy clears (a same-cycle set wins).
// busy_vec always shows registered state.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   rd_addr/rd_data       : packed per-port read address / data
//   rd_busy               : busy flag of each port's addressed register
//   w0_en/w0_addr/w0_data : ALU write port
//   w1_en/w1_addr/w1_data : memory write port, clears busy
//   sb_set_en/sb_set_addr : mark a destination busy at issue
//   busy_vec              : full scoreboard state
module rf_multiport_sb
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH  = RF_WIDTH,
    parameter int unsigned DEPTH  = RF_DEPTH,
    parameter int unsigned NUM_RD = 2,
    localparam int unsigned AW = rf_aw(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic                    w0_en,
    input  logic [AW-1:0]           w0_addr,
    input  logic [WIDTH-1:0]        w0_data,
    input  logic                    w1_en,
    input  logic [AW-1:0]           w1_addr,
    input  logic [WIDTH-1:0]        w1_data,
    input  logic                    sb_set_en,
    input  logic [AW-1:0]           sb_set_addr,
    output logic [DEPTH-1:0]        busy_vec
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [WIDTH-1:0] mem [DEPTH];

    // W1 is written after W0 so a same-address collision keeps W1's data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (w0_en && (w0_addr != ZERO_ADDR)) begin
                mem[w0_addr] <= w0_data;
            end
            if (w1_en && (w1_addr != ZERO_ADDR)) begin
                mem[w1_addr] <= w1_data;
            end
        end
    end

    rf_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (sb_set_en),
        .set_addr (sb_set_addr),
        .clr_en   (w1_en),
        .clr_addr (w1_addr),
        .busy_vec (busy_vec)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             busy;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            data = mem[addr];
            busy = busy_vec[addr];
            if (addr == ZERO_ADDR) begin
                data = '0;
                busy = 1'b0;
            end
`ifdef RF_BYPASS_EN
            else begin
                if (w1_en && (w1_addr == addr)) begin
                    data = w1_data;
                end else if (w0_en && (w0_addr == addr)) begin
                    data = w0_data;
                end
                // A completing load frees the register unless it is re-issued now.
                if (w1_en && (w1_addr == addr)) begin
                    busy = sb_set_en && (sb_set_addr == addr);
                end
            end
`endif
        end

        assign rd_data[i*WIDTH +: WIDTH] = data;
        assign rd_busy[i]                = busy;
    end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Self-checking bench for rf_multiport_sb (WIDTH=32, DEPTH=32, NUM_RD=2).
// A behavioural register-file model is compared against the DUT every cycle,
// and directed scenarios carry hand-computed literal expectations.
module tb_rf_multiport_sb;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned AW     = 5;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]       rd_busy;
    logic                    w0_en;
    logic [AW-1:0]           w0_addr;
    logic [WIDTH-1:0]        w0_data;
    logic                    w1_en;
    logic [AW-1:0]           w1_addr;
    logic [WIDTH-1:0]        w1_data;
    logic                    sb_set_en;
    logic [AW-1:0]           sb_set_addr;
    logic [DEPTH-1:0]        busy_vec;

    rf_multiport_sb #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .w0_en       (w0_en),
        .w0_addr     (w0_addr),
        .w0_data     (w0_data),
        .w1_en       (w1_en),
        .w1_addr     (w1_addr),
        .w1_data     (w1_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .busy_vec    (busy_vec)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    logic [WIDTH-1:0] m_mem  [DEPTH];
    bit               m_busy [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model state: a plain array of values and an array of busy flags.
    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (w0_en && w0_addr != 0) m_mem[w0_addr] = w0_data;
            if (w1_en && w1_addr != 0) m_mem[w1_addr] = w1_data;
            if (w1_en) m_busy[w1_addr] = 1'b0;
            if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (w1_en && w1_addr == a) return w1_data;
        if (w0_en && w0_addr == a) return w0_data;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (w1_en && w1_addr == a) return sb_set_en && sb_set_addr == a;
`endif
        return m_busy[a];
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            logic [DEPTH-1:0] bv;
            for (int r = 0; r < int'(DEPTH); r++) bv[r] = m_busy[r];
            for (int p = 0; p < int'(NUM_RD); p++) begin
                check($sformatf("model rd_data[%0d] @%0t", p, $time),
                      rd_data[p*WIDTH +: WIDTH], exp_data(rd_addr[p*AW +: AW]));
                check($sformatf("model rd_busy[%0d] @%0t", p, $time),
                      32'(rd_busy[p]), 32'(exp_busy(rd_addr[p*AW +: AW])));
            end
            check($sformatf("model busy_vec @%0t", $time), busy_vec, bv);
        end
    end

    task automatic idle();
        w0_en = 1'b0; w0_addr = '0; w0_data = '0;
        w1_en = 1'b0; w1_addr = '0; w1_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        reset = 1'b1;
        idle();
        set_rd(0, 0);
        repeat (2) tick();
        reset = 1'b0;
        check_en = 1'b1;

        // Reset state on every address.
        for (int a = 0; a < int'(DEPTH); a++) begin
            set_rd(AW'(a), AW'(31 - a));
            #2;
            check("reset rd_data0", rd_data[31:0], 32'h0);
            check("reset rd_data1", rd_data[63:32], 32'h0);
            check("reset rd_busy", 32'(rd_busy), 32'h0);
            check("reset busy_vec", busy_vec, 32'h0);
            tick();
        end

        // Plain write then read.
        set_rd(5, 0);
        w0_en = 1'b1; w0_addr = 5; w0_data = 32'hDEADBEEF;
        tick();
        idle();
        #2;
        check("w0 addr5", rd_data[31:0], 32'hDEADBEEF);

        // Register 0 ignores writes and sets.
        w0_en = 1'b1; w0_addr = 0; w0_data = 32'h1234;
        w1_en = 1'b1; w1_addr = 0; w1_data = 32'h5678;
        sb_set_en = 1'b1; sb_set_addr = 0;
        tick();
        idle();
        set_rd(0, 0);
        #2;
        check("addr0 data", rd_data[31:0], 32'h0);
        check("addr0 busy_vec", busy_vec, 32'h0);

        // W1 wins a same-address collision.
        w0_en = 1'b1; w0_addr = 7; w0_data = 32'h11;
        w1_en = 1'b1; w1_addr = 7; w1_data = 32'h22;
        tick();
        idle();
        set_rd(7, 5);
        #2;
        check("w1 priority", rd_data[31:0], 32'h22);
        check("port1 keeps addr5", rd_data[63:32], 32'hDEADBEEF);

        // Scoreboard set, clear, set-over-clear.
        sb_set_en = 1'b1; sb_set_addr = 9;
        tick();
        idle();
        set_rd(9, 9);
        #2;
        check("sb set busy_vec", busy_vec, 32'h0000_0200);
        check("sb set rd_busy", 32'(rd_busy), 32'h3);
        tick();
        w1_en = 1'b1; w1_addr = 9; w1_data = 32'h99;
        tick();
        idle();
        #2;
        check("sb clr busy_vec", busy_vec, 32'h0);
        check("sb clr rd_busy", 32'(rd_busy), 32'h0);
        check("sb clr data", rd_data[63:32], 32'h99);
        sb_set_en = 1'b1; sb_set_addr = 9;
        tick();
        w1_en = 1'b1; w1_addr = 9; w1_data = 32'h77;
        tick();
        idle();
        #2;
        check("set beats clr", busy_vec, 32'h0000_0200);
        check("set beats clr data", rd_data[31:0], 32'h77);
        w1_en = 1'b1; w1_addr = 9; w1_data = 32'h78;
        tick();
        idle();

        // Same-cycle forwarding behaviour.
        w0_en = 1'b1; w0_addr = 3; w0_data = 32'h5A;
        sb_set_en = 1'b1; sb_set_addr = 3;
        tick();
        idle();
        set_rd(3, 0);
        w1_en = 1'b1; w1_addr = 3; w1_data = 32'hA5;
        #2;
`ifdef RF_BYPASS_EN
        check("bypass data", rd_data[31:0], 32'hA5);
        check("bypass busy", 32'(rd_busy[0]), 32'h0);
`else
        check("no-bypass data", rd_data[31:0], 32'h5A);
        check("no-bypass busy", 32'(rd_busy[0]), 32'h1);
`endif
        tick();
        idle();
        #2;
        check("after w1 data", rd_data[31:0], 32'hA5);
        check("after w1 busy", 32'(rd_busy[0]), 32'h0);

        // Mixed traffic for the model comparison.
        for (int i = 1; i < int'(DEPTH); i++) begin
            w0_en = 1'b1; w0_addr = AW'(i); w0_data = 32'(i) * 32'h0101_0101;
            w1_en = (i % 3) == 0; w1_addr = AW'(i * 7); w1_data = ~32'(i);
            sb_set_en = (i % 2) == 1; sb_set_addr = AW'(i * 3);
            set_rd(AW'(i), AW'(i * 7));
            tick();
        end
        idle();
        tick();

        // Reset overrides concurrent writes and sets.
        reset = 1'b1;
        w0_en = 1'b1; w0_addr = 4; w0_data = 32'h44;
        w1_en = 1'b1; w1_addr = 6; w1_data = 32'h66;
        sb_set_en = 1'b1; sb_set_addr = 8;
        tick();
        reset = 1'b0;
        idle();
        set_rd(4, 6);
        #2;
        check("reset mid-run data4", rd_data[31:0], 32'h0);
        check("reset mid-run data6", rd_data[63:32], 32'h0);
        check("reset mid-run busy_vec", busy_vec, 32'h0);
        set_rd(8, 5);
        #1;
        check("reset mid-run busy8", 32'(rd_busy), 32'h0);
        check("reset mid-run data5", rd_data[63:32], 32'h0);
        repeat (2) tick();

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
